// File: rtl/fp_classify_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_classify_pipe_if
// Description : Operand/result handshake bundle and statistics signals for
//               the pipelined floating-point operand classifier.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_classify_pipe_if #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int CNT_W  = 16
);
    localparam int c_DATA_W = EXP_W + FRAC_W + 1;

    logic                in_valid;
    logic                in_ready;
    logic [c_DATA_W-1:0] in_data;
    logic                out_valid;
    logic                out_ready;
    logic [c_DATA_W-1:0] out_data;
    logic [9:0]          out_class;
    logic                stat_clr;
    logic [CNT_W-1:0]    nan_cnt;
    logic [CNT_W-1:0]    sub_cnt;

    // Producer/consumer side of the classifier
    modport master (
        output in_valid, in_data, out_ready, stat_clr,
        input  in_ready, out_valid, out_data, out_class, nan_cnt, sub_cnt
    );

    // Classifier side
    modport slave (
        input  in_valid, in_data, out_ready, stat_clr,
        output in_ready, out_valid, out_data, out_class, nan_cnt, sub_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fp_classify_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fp_classify_pipe
// Description : Two-stage valid/ready pipeline that classifies an IEEE-754
//               style operand into a 10-bit one-hot class and keeps
//               saturating NaN / subnormal result counters.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_classify_pipe #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    fp_classify_pipe_if.slave  bus
);
    localparam int c_DATA_W = EXP_W + FRAC_W + 1;

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    localparam logic [9:0] c_CLS_NEG_INF  = 10'b00_0000_0001;
    localparam logic [9:0] c_CLS_NEG_NORM = 10'b00_0000_0010;
    localparam logic [9:0] c_CLS_NEG_SUB  = 10'b00_0000_0100;
    localparam logic [9:0] c_CLS_NEG_ZERO = 10'b00_0000_1000;
    localparam logic [9:0] c_CLS_POS_ZERO = 10'b00_0001_0000;
    localparam logic [9:0] c_CLS_POS_SUB  = 10'b00_0010_0000;
    localparam logic [9:0] c_CLS_POS_NORM = 10'b00_0100_0000;
    localparam logic [9:0] c_CLS_POS_INF  = 10'b00_1000_0000;
    localparam logic [9:0] c_CLS_SNAN     = 10'b01_0000_0000;
    localparam logic [9:0] c_CLS_QNAN     = 10'b10_0000_0000;

    // Stage 1 state
    logic                r_s1Valid;
    logic [c_DATA_W-1:0] r_s1Data;
    logic                r_s1ExpOnes;
    logic                r_s1ExpZero;
    logic                r_s1FracZero;
    logic                r_s1FracMsb;

    // Stage 2 state
    logic                r_s2Valid;
    logic [c_DATA_W-1:0] r_s2Data;
    logic [9:0]          r_s2Class;

    // Statistics
    logic [CNT_W-1:0]    r_nanCnt;
    logic [CNT_W-1:0]    r_subCnt;

    logic                w_s1Adv;
    logic                w_s2Adv;
    logic                w_inHs;
    logic                w_outHs;
    logic [EXP_W-1:0]    w_expField;
    logic [FRAC_W-1:0]   w_fracField;
    logic                w_s1Sign;
    logic [9:0]          w_class;
    logic                w_isNan;
    logic                w_isSub;

    // A stage may take new data when it is empty or its content leaves
    assign w_s2Adv = ~r_s2Valid | bus.out_ready;
    assign w_s1Adv = ~r_s1Valid | w_s2Adv;

    // Held low during reset so nothing is accepted into a clearing pipe
    assign bus.in_ready = w_s1Adv & ~rst;
    assign w_inHs       = bus.in_valid & bus.in_ready;
    assign w_outHs      = r_s2Valid & bus.out_ready;

    assign w_expField  = bus.in_data[c_DATA_W-2 -: EXP_W];
    assign w_fracField = bus.in_data[FRAC_W-1:0];
    assign w_s1Sign    = r_s1Data[c_DATA_W-1];

    // Stage 1: capture operand with its exponent/fraction summary flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1Valid    <= 1'b0;
            r_s1Data     <= '0;
            r_s1ExpOnes  <= 1'b0;
            r_s1ExpZero  <= 1'b0;
            r_s1FracZero <= 1'b0;
            r_s1FracMsb  <= 1'b0;
        end else if (w_s1Adv) begin
            r_s1Valid <= w_inHs;
            if (w_inHs) begin
                r_s1Data     <= bus.in_data;
                r_s1ExpOnes  <= &w_expField;
                r_s1ExpZero  <= ~|w_expField;
                r_s1FracZero <= ~|w_fracField;
                r_s1FracMsb  <= w_fracField[FRAC_W-1];
            end
        end
    end

    // Decode the one-hot class from the stage 1 flags; NaNs ignore sign
    always_comb begin
        w_class = '0;
        if (r_s1ExpOnes) begin
            if (r_s1FracZero)
                w_class = w_s1Sign ? c_CLS_NEG_INF : c_CLS_POS_INF;
            else if (r_s1FracMsb)
                w_class = c_CLS_QNAN;
            else
                w_class = c_CLS_SNAN;
        end else if (r_s1ExpZero) begin
            if (r_s1FracZero)
                w_class = w_s1Sign ? c_CLS_NEG_ZERO : c_CLS_POS_ZERO;
            else
                w_class = w_s1Sign ? c_CLS_NEG_SUB : c_CLS_POS_SUB;
        end else begin
            w_class = w_s1Sign ? c_CLS_NEG_NORM : c_CLS_POS_NORM;
        end
    end

    // Stage 2: register operand and class; hold while the consumer stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2Valid <= 1'b0;
            r_s2Data  <= '0;
            r_s2Class <= '0;
        end else if (w_s2Adv) begin
            r_s2Valid <= r_s1Valid;
            if (r_s1Valid) begin
                r_s2Data  <= r_s1Data;
                r_s2Class <= w_class;
            end
        end
    end

    assign w_isNan = r_s2Class[8] | r_s2Class[9];
    assign w_isSub = r_s2Class[2] | r_s2Class[5];

    // Saturating result counters; a clear overrides a same-cycle increment
    always_ff @(posedge clk) begin
        if (rst || bus.stat_clr) begin
            r_nanCnt <= '0;
            r_subCnt <= '0;
        end else begin
            if (w_outHs && w_isNan && (r_nanCnt != c_CNT_MAX))
                r_nanCnt <= r_nanCnt + 1'b1;
            if (w_outHs && w_isSub && (r_subCnt != c_CNT_MAX))
                r_subCnt <= r_subCnt + 1'b1;
        end
    end

    assign bus.out_valid = r_s2Valid;
    assign bus.out_data  = r_s2Data;
    assign bus.out_class = r_s2Class;
    assign bus.nan_cnt   = r_nanCnt;
    assign bus.sub_cnt   = r_subCnt;

endmodule
`default_nettype wire

// File: tb/tb_fp_classify_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_classify_pipe
// Description : Self-checking bench for fp_classify_pipe: a binary64 instance
//               and a binary16 instance with 2-bit counters, checked cycle by
//               cycle against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_classify_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Shared stimulus; sel chooses which instance is active (0: binary64)
    logic        sel;
    logic        inValid;
    logic [63:0] inData;
    logic        outReady;
    logic        statClr;

    fp_classify_pipe_if #(.EXP_W(11), .FRAC_W(52), .CNT_W(16)) busD ();
    fp_classify_pipe_if #(.EXP_W(5),  .FRAC_W(10), .CNT_W(2))  busH ();

    fp_classify_pipe #(.EXP_W(11), .FRAC_W(52), .CNT_W(16)) dutD (
        .clk (clk),
        .rst (rst),
        .bus (busD)
    );

    fp_classify_pipe #(.EXP_W(5), .FRAC_W(10), .CNT_W(2)) dutH (
        .clk (clk),
        .rst (rst),
        .bus (busH)
    );

    assign busD.in_valid  = inValid & ~sel;
    assign busD.in_data   = inData;
    assign busD.out_ready = outReady;
    assign busD.stat_clr  = statClr;
    assign busH.in_valid  = inValid & sel;
    assign busH.in_data   = inData[15:0];
    assign busH.out_ready = outReady;
    assign busH.stat_clr  = statClr;

    logic        wInReady;
    logic        wOutValid;
    logic [63:0] wOutData;
    logic [9:0]  wOutClass;
    logic [15:0] wNanCnt;
    logic [15:0] wSubCnt;

    assign wInReady  = sel ? busH.in_ready  : busD.in_ready;
    assign wOutValid = sel ? busH.out_valid : busD.out_valid;
    assign wOutData  = sel ? {48'd0, busH.out_data} : busD.out_data;
    assign wOutClass = sel ? busH.out_class : busD.out_class;
    assign wNanCnt   = sel ? {14'd0, busH.nan_cnt} : busD.nan_cnt;
    assign wSubCnt   = sel ? {14'd0, busH.sub_cnt} : busD.sub_cnt;

    int nChecks;
    int nPass;
    int cyc;

    // Reference model state
    logic [63:0] qData[$];
    int          qCyc[$];
    int          mNan;
    int          mSub;
    bit          heldValid;
    logic [63:0] heldData;
    logic [9:0]  heldClass;
    bit          lastInHs;

    function automatic int expW();   return sel ? 5 : 11;       endfunction
    function automatic int fracW();  return sel ? 10 : 52;      endfunction
    function automatic int cntMax(); return sel ? 3 : 65535;    endfunction

    task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] expVal);
        nChecks++;
        if (obs === expVal)
            nPass++;
        else
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, expVal, cyc);
    endtask

    // Class from the textbook IEEE-754 field rules
    function automatic logic [9:0] refClass(input logic [63:0] d, input int ew, input int fw);
        logic [63:0] emax, e, f;
        bit          s;
        emax = (64'd1 << ew) - 64'd1;
        e    = (d >> fw) & emax;
        f    = d & ((64'd1 << fw) - 64'd1);
        s    = d[ew + fw];
        if (e == emax) begin
            if (f == 0)                  return s ? 10'h001 : 10'h080;
            else if (f[fw - 1])          return 10'h200;
            else                         return 10'h100;
        end else if (e == 0) begin
            if (f == 0)                  return s ? 10'h008 : 10'h010;
            else                         return s ? 10'h004 : 10'h020;
        end
        return s ? 10'h002 : 10'h040;
    endfunction

    // Random operand biased toward the special exponent/fraction patterns
    function automatic logic [63:0] randOp(input int ew, input int fw);
        logic [63:0] emax, fmask, e, f, r;
        int k;
        emax  = (64'd1 << ew) - 64'd1;
        fmask = (64'd1 << fw) - 64'd1;
        r     = {$urandom, $urandom};
        k     = $urandom_range(0, 3);
        e     = (k == 0) ? 64'd0 : (k == 1) ? emax : (r & emax);
        r     = {$urandom, $urandom};
        k     = $urandom_range(0, 3);
        case (k)
            0:       f = 64'd0;
            1:       f = (64'd1 << (fw - 1)) | (r & fmask);
            2:       f = r & (fmask >> 1);
            default: f = r & fmask;
        endcase
        return (64'($urandom_range(0, 1)) << (ew + fw)) | (e << fw) | f;
    endfunction

    // One clock: compare at the falling edge, advance the model, return after the rising edge
    task automatic tick();
        int         n;
        bit         expReady, expValid;
        logic [9:0] cls;
        @(negedge clk);
        n        = qData.size();
        expReady = (n < 2) || outReady;
        expValid = 1'b0;
        cls      = '0;
        if (n > 0) begin
            expValid = (cyc - qCyc[0]) >= 2;
            cls      = refClass(qData[0], expW(), fracW());
        end
        checkEq("in_ready", 64'(wInReady), 64'(expReady));
        checkEq("out_valid", 64'(wOutValid), 64'(expValid));
        if (heldValid) begin
            checkEq("hold_data", wOutData, heldData);
            checkEq("hold_class", 64'(wOutClass), 64'(heldClass));
        end
        if (expValid) begin
            checkEq("out_data", wOutData, qData[0]);
            checkEq("out_class", 64'(wOutClass), 64'(cls));
        end
        checkEq("nan_cnt", 64'(wNanCnt), 64'(mNan));
        checkEq("sub_cnt", 64'(wSubCnt), 64'(mSub));
        heldValid = wOutValid && !outReady;
        heldData  = wOutData;
        heldClass = wOutClass;
        if (expValid && outReady) begin
            void'(qData.pop_front());
            void'(qCyc.pop_front());
            if (!statClr) begin
                if ((cls[8] || cls[9]) && mNan < cntMax()) mNan++;
                if ((cls[2] || cls[5]) && mSub < cntMax()) mSub++;
            end
        end
        if (statClr) begin
            mNan = 0;
            mSub = 0;
        end
        lastInHs = inValid && expReady;
        if (lastInHs) begin
            qData.push_back(inData);
            qCyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic doReset();
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        statClr  = 1'b0;
        @(negedge clk);
        checkEq("rst_in_ready", 64'(wInReady), 64'd0);
        @(posedge clk);
        #1;
        cyc++;
        @(negedge clk);
        checkEq("rst_in_ready2", 64'(wInReady), 64'd0);
        checkEq("rst_out_valid", 64'(wOutValid), 64'd0);
        checkEq("rst_out_data", wOutData, 64'd0);
        checkEq("rst_out_class", 64'(wOutClass), 64'd0);
        checkEq("rst_nan_cnt", 64'(wNanCnt), 64'd0);
        checkEq("rst_sub_cnt", 64'(wSubCnt), 64'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst       = 1'b0;
        outReady  = 1'b1;
        qData.delete();
        qCyc.delete();
        mNan      = 0;
        mSub      = 0;
        heldValid = 1'b0;
    endtask

    task automatic send(input logic [63:0] d);
        int guard;
        inValid = 1'b1;
        inData  = d;
        guard   = 0;
        do begin
            tick();
            guard++;
        end while (!lastInHs && guard < 20);
        checkEq("send_accept", 64'(lastInHs), 64'd1);
        inValid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        inValid  = 1'b0;
        outReady = 1'b1;
        statClr  = 1'b0;
        guard    = 0;
        while (qData.size() > 0 && guard < 50) begin
            tick();
            guard++;
        end
        checkEq("drain_empty", 64'(qData.size()), 64'd0);
        tick();
    endtask

    task automatic randomRun(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            inData   = randOp(expW(), fracW());
            outReady = ($urandom_range(0, 3) != 0);
            statClr  = ($urandom_range(0, 31) == 0);
            tick();
        end
        drain();
    endtask

    initial begin
        logic [63:0] bp[5];
        int idx;
        nChecks  = 0;
        nPass    = 0;
        cyc      = 0;
        sel      = 1'b0;
        inData   = '0;
        rst      = 1'b1;
        inValid  = 1'b0;
        outReady = 1'b0;
        statClr  = 1'b0;
        lastInHs = 1'b0;
        @(posedge clk);
        #1;
        doReset();

        // binary64: back-to-back classic values
        send(64'h3FF0000000000000);
        send(64'h8000000000000000);
        send(64'h0000000000000001);
        send(64'hFFF0000000000000);
        drain();

        // NaN split with fresh counters
        statClr = 1'b1;
        tick();
        statClr = 1'b0;
        send(64'h7FF8000000000000);
        send(64'h7FF0000000000001);
        send(64'hFFF8000000000000);
        drain();
        checkEq("nan_total", 64'(wNanCnt), 64'd3);
        checkEq("sub_after_nan", 64'(wSubCnt), 64'd0);

        // Backpressure: consumer stalls for four cycles mid-stream
        bp[0] = 64'h4000000000000000; bp[1] = 64'h000FFFFFFFFFFFFF;
        bp[2] = 64'h7FF4000000000000; bp[3] = 64'h0000000000000000;
        bp[4] = 64'h7FF0000000000000;
        idx = 0;
        for (int k = 0; k < 20 && idx < 5; k++) begin
            inValid  = 1'b1;
            inData   = bp[idx];
            outReady = !(k >= 2 && k < 6);
            tick();
            if (lastInHs) idx++;
        end
        checkEq("bp_all_sent", 64'(idx), 64'd5);
        drain();

        randomRun(300);

        // Reset with both stages occupied
        outReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            inValid = 1'b1;
            inData  = 64'h7FF8000000000000;
            tick();
        end
        doReset();
        for (int k = 0; k < 4; k++) tick();

        // binary16 instance
        sel = 1'b1;
        doReset();
        send(64'h7C00);
        send(64'h7E00);
        send(64'h03FF);
        send(64'h3C00);
        drain();

        for (int k = 0; k < 5; k++) send(64'h0001 + 64'(k));
        drain();
        checkEq("sub_saturate", 64'(wSubCnt), 64'd3);

        // Clear coinciding with a counted subnormal handshake
        send(64'h8001);
        tick();
        statClr = 1'b1;
        tick();
        statClr = 1'b0;
        checkEq("clr_wins", 64'(wSubCnt), 64'd0);
        drain();

        randomRun(200);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_classify_pipe.md
# fp_classify_pipe

Pipelined, parametrised floating-point operand classifier for the multiplier datapath. Accepts a full signed IEEE-754-style operand (sign, EXP_W exponent, FRAC_W fraction) over a valid/ready handshake. Returns a 10-bit one-hot class vector that distinguishes sign, zero/subnormal/normal/infinity and signalling/quiet NaN. Keeps saturating counts of NaN and subnormal operands for debug and statistics.

## Interface
Parameters:
- EXP_W, 11, exponent width; legal range 2..15.
- FRAC_W, 52, fraction width; legal range 2..112.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  EXP_W+FRAC_W+1  operand: [MSB] sign, then exponent, then fraction in [FRAC_W-1:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  EXP_W+FRAC_W+1  operand passed through unchanged.
- out_class  out  10  one-hot class. Bits: 0 −inf, 1 −normal, 2 −subnormal, 3 −zero, 4 +zero, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
- stat_clr  in  1  clears both counters.
- nan_cnt  out  CNT_W  number of NaN results (sNaN or qNaN) delivered.
- sub_cnt  out  CNT_W  number of subnormal results (±) delivered.

## Operation
- Stage 1 (S1) registers the operand together with three flags: exp_ones (exponent all ones), exp_zero (exponent all zeros) and frac_zero (fraction all zeros). It also registers frac_msb, the fraction MSB.
- Stage 2 (S2) registers the operand and the one-hot class decoded from the S1 flags and the sign:
  - exp_zero & frac_zero → ±zero.
  - exp_zero & ~frac_zero → ±subnormal.
  - ~exp_zero & ~exp_ones → ±normal.
  - exp_ones & frac_zero → ±inf.
  - exp_ones & ~frac_zero & frac_msb → qNaN. NaN sign is ignored.
  - exp_ones & ~frac_zero & ~frac_msb → sNaN.
- Exactly one bit of out_class is set whenever out_valid=1.
- Counters update only on an output handshake (out_valid & out_ready):
  - nan_cnt increments when class bit 8 or 9 is set.
  - sub_cnt increments when class bit 2 or 5 is set.
  - Both counters saturate at 2^CNT_W−1 and never wrap.
- stat_clr zeroes both counters next cycle. If stat_clr coincides with a counted handshake, the clear wins and the counter ends at 0. The pipeline is not affected by stat_clr.

## Timing
- Reset: S1 and S2 valid bits = 0, out_valid=0, nan_cnt=sub_cnt=0. out_data and out_class read 0 after reset. In reset cycles in_ready=0. Reset mid-operation discards both stages without producing output.
- Latency: an operand accepted in cycle N appears with out_valid=1 in cycle N+2 if out_ready was held high.
- Throughput: one operand per cycle when out_ready=1.
- Stage advance: s2_adv = ~s2_valid | out_ready; s1_adv = ~s1_valid | s2_adv; in_ready = s1_adv.
- in_ready depends combinationally on out_ready. There is no path from in_valid to in_ready.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_class hold stable. With both stages full, in_ready=0.
- A stage holds its contents until they move downstream.
- Bubbles: an empty stage fills regardless of downstream stall.
- Simultaneous events:
  - Handshakes on input and output in the same cycle move both stages forward.
  - Operand order is preserved; no drops and no duplicates.

## Test plan
- Default parameters, out_ready=1, back-to-back inputs 0x3FF0000000000000, 0x8000000000000000, 0x0000000000000001, 0xFFF0000000000000 → classes 0x040, 0x008, 0x020, 0x001 arrive in order, two cycles after their inputs, each with its input echoed on out_data.
- NaN split: 0x7FF8000000000000 → 0x200; 0x7FF0000000000001 → 0x100; 0xFFF8000000000000 → 0x200. After draining: nan_cnt=3, sub_cnt=0.
- Backpressure: stream 5 operands with out_ready low for 4 cycles mid-stream → in_ready drops after 2 are held; out_data/out_class stay stable; all 5 are delivered in order with no loss.
- Counters: CNT_W=2, send 5 subnormals → sub_cnt stops at 3. Assert stat_clr in the same cycle as a subnormal handshake → sub_cnt=0 next cycle.
- Reset mid-flight: rst while both stages are valid → next cycle out_valid=0, counters 0, and no stale result is delivered after reset.
- Parameter sweep EXP_W=5, FRAC_W=10 (binary16): 0x7C00 → 0x080, 0x7E00 → 0x200, 0x03FF → 0x020, 0x3C00 → 0x040.
